// File: rtl/cons_txd.sv
// Console transmit responder on the KS10 CPU bus.
// Accepts IO writes of characters into a FIFO and sends them 8N1, LSB first, on o_con_txd.
// IO reads return status. A transmit-ready interrupt is optional.
//
// KS10 bit numbering [0:35] (bit 0 = MSB) maps onto [35:0] here, so KS10 bit n is index 35-n.
// The address [14:35] maps onto [21:0] the same way.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_clken      clock enable; bus decode and all state advance only when 1
//   i_cpu_read   CPU read request
//   i_cpu_write  CPU write request
//   i_cpu_io     request is IO space
//   i_cpu_addr   request address
//   i_cpu_data   CPU write data
//   o_txd_data   read data to arbiter; 0 outside the ack cycle
//   o_txd_ack    one-cycle acknowledge to arbiter
//   o_con_txd    serial output, idle high
//   o_tx_irq     registered interrupt request (IRQEN & TXRDY)
module cons_txd #(
   parameter int unsigned ClkFrq = 50000000,
   parameter int unsigned Baud   = 9600,
   parameter logic [21:0] Base   = 22'o0200000,
   parameter int unsigned Depth  = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clken,
   input  logic        i_cpu_read,
   input  logic        i_cpu_write,
   input  logic        i_cpu_io,
   input  logic [21:0] i_cpu_addr,
   input  logic [35:0] i_cpu_data,
   output logic [35:0] o_txd_data,
   output logic        o_txd_ack,
   output logic        o_con_txd,
   output logic        o_tx_irq
);

   localparam int unsigned Div   = ClkFrq / Baud;
   localparam int unsigned TmrW  = $clog2(Div);
   localparam int unsigned AddrW = $clog2(Depth);

   localparam logic [TmrW-1:0]  TmrLast = TmrW'(Div - 1);
   localparam logic [TmrW-1:0]  TmrOne  = TmrW'(1);
   localparam logic [AddrW:0]   CntFull = (AddrW + 1)'(Depth);
   localparam logic [AddrW:0]   CntOne  = (AddrW + 1)'(1);
   localparam logic [AddrW-1:0] PtrOne  = AddrW'(1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // Bus decode and request capture
   logic w_hit_data, w_hit_stat, w_sel;
   logic r_busy, r_ack, r_wr, r_stat;
   logic [7:0] r_wbyte;

   assign w_hit_data = (i_cpu_addr == Base);
   assign w_hit_stat = (i_cpu_addr == Base + 22'd1);
   assign w_sel      = i_cpu_io & (i_cpu_read | i_cpu_write) & (w_hit_data | w_hit_stat);

   // r_busy remembers a request already acknowledged, so a held request acks only once.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy  <= 1'b0;
         r_ack   <= 1'b0;
         r_wr    <= 1'b0;
         r_stat  <= 1'b0;
         r_wbyte <= 8'd0;
      end else if (i_clken) begin
         r_busy <= w_sel;
         r_ack  <= w_sel & ~r_busy;
         if (w_sel && !r_busy) begin
            r_wr    <= i_cpu_write;
            r_stat  <= w_hit_stat;
            r_wbyte <= i_cpu_data[7:0];
         end
      end
   end

   // Side effects are applied in the ack cycle, once per request.
   logic w_wr_ev, w_push_req, w_stat_wr;
   assign w_wr_ev    = i_clken & r_ack & r_wr;
   assign w_push_req = w_wr_ev & ~r_stat;
   assign w_stat_wr  = w_wr_ev & r_stat;

   // Character FIFO
   logic [7:0]       r_mem [Depth];
   logic [AddrW-1:0] r_wptr, r_rptr;
   logic [AddrW:0]   r_count;
   logic             w_empty, w_full, w_push, w_pop, w_bit_end;

   state_e         r_state;
   logic [TmrW-1:0] r_tmr;
   logic [2:0]     r_bitcnt;
   logic [7:0]     r_shift;
   logic           r_txd;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CntFull);
   assign w_bit_end = (r_tmr == TmrLast);
   assign w_pop     = i_clken & ~w_empty &
                      ((r_state == StIdle) | ((r_state == StStop) & w_bit_end));
   // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted.
   assign w_push    = w_push_req & (~w_full | w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PtrOne;
         if (w_pop)  r_rptr <= r_rptr + PtrOne;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CntOne;
            2'b01:   r_count <= r_count - CntOne;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= r_wbyte;
   end

   // Status / interrupt
   logic r_ovf, r_irqen, r_irq;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ovf   <= 1'b0;
         r_irqen <= 1'b0;
         r_irq   <= 1'b0;
      end else if (i_clken) begin
         if (w_push_req && w_full && !w_pop) begin
            r_ovf <= 1'b1;
         end else if (w_stat_wr && r_wbyte[2]) begin
            r_ovf <= 1'b0;
         end
         if (w_stat_wr) r_irqen <= r_wbyte[3];
         r_irq <= r_irqen & ~w_full;
      end
   end

   logic        w_tx_empty;
   logic [35:0] w_status;
   assign w_tx_empty = w_empty & (r_state == StIdle);
   assign w_status   = {32'd0, r_irqen, r_ovf, ~w_full, w_tx_empty};

   assign o_txd_ack  = r_ack;
   assign o_txd_data = (r_ack && !r_wr && r_stat) ? w_status : 36'd0;
   assign o_tx_irq   = r_irq;
   assign o_con_txd  = r_txd;

   // Transmitter; r_txd is loaded on each bit transition so the line follows the state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_tmr    <= '0;
         r_bitcnt <= 3'd0;
         r_shift  <= 8'd0;
         r_txd    <= 1'b1;
      end else if (i_clken) begin
         unique case (r_state)
            StIdle: begin
               r_txd <= 1'b1;
               if (!w_empty) begin
                  r_shift <= r_mem[r_rptr];
                  r_tmr   <= '0;
                  r_txd   <= 1'b0;
                  r_state <= StStart;
               end
            end
            StStart: begin
               if (w_bit_end) begin
                  r_tmr    <= '0;
                  r_bitcnt <= 3'd0;
                  r_txd    <= r_shift[0];
                  r_state  <= StData;
               end else begin
                  r_tmr <= r_tmr + TmrOne;
               end
            end
            StData: begin
               if (w_bit_end) begin
                  r_tmr <= '0;
                  if (r_bitcnt == 3'd7) begin
                     r_txd   <= 1'b1;
                     r_state <= StStop;
                  end else begin
                     r_bitcnt <= r_bitcnt + 3'd1;
                     r_txd    <= r_shift[r_bitcnt + 3'd1];
                  end
               end else begin
                  r_tmr <= r_tmr + TmrOne;
               end
            end
            StStop: begin
               if (w_bit_end) begin
                  r_tmr <= '0;
                  if (!w_empty) begin
                     // Next character starts with no idle gap.
                     r_shift <= r_mem[r_rptr];
                     r_txd   <= 1'b0;
                     r_state <= StStart;
                  end else begin
                     r_state <= StIdle;
                  end
               end else begin
                  r_tmr <= r_tmr + TmrOne;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   logic w_unused;
   assign w_unused = ^i_cpu_data[35:8];

endmodule

// File: tb/tb_cons_txd.sv
// Directed self-checking bench for cons_txd (DIV = 16, DEPTH = 8).
module tb_cons_txd;

   localparam logic [21:0] BASE = 22'o0200000;

   logic        clk, rst_n, clken;
   logic        cpu_read, cpu_write, cpu_io;
   logic [21:0] cpu_addr;
   logic [35:0] cpu_data;
   logic [35:0] txd_data;
   logic        txd_ack, con_txd, tx_irq;

   int n_tests = 0;
   int n_fail  = 0;

   cons_txd #(
      .ClkFrq(1600),
      .Baud  (100),
      .Base  (BASE),
      .Depth (8)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_clken    (clken),
      .i_cpu_read (cpu_read),
      .i_cpu_write(cpu_write),
      .i_cpu_io   (cpu_io),
      .i_cpu_addr (cpu_addr),
      .i_cpu_data (cpu_data),
      .o_txd_data (txd_data),
      .o_txd_ack  (txd_ack),
      .o_con_txd  (con_txd),
      .o_tx_irq   (tx_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drives one request for 'hold' cycles, then observes one more cycle.
   task automatic bus_req(input logic w, input logic sp_io, input logic [21:0] a,
                          input logic [35:0] d, input int hold, output int acks,
                          output logic [35:0] rdata, output int ack_at, output int stray);
      acks = 0; rdata = '0; ack_at = -1; stray = 0;
      @(negedge clk);
      cpu_read = ~w; cpu_write = w; cpu_io = sp_io; cpu_addr = a; cpu_data = d;
      for (int c = 1; c <= hold + 1; c++) begin
         @(negedge clk);
         if (txd_ack === 1'b1) begin
            acks++;
            rdata = txd_data;
            if (ack_at < 0) ack_at = c;
         end else if (txd_data !== 36'd0) begin
            stray++;
         end
         if (c == hold) begin
            cpu_read = 0; cpu_write = 0; cpu_io = 0; cpu_addr = '0; cpu_data = '0;
         end
      end
   endtask

   // Receives one 8N1 character; gap = high samples before the start bit.
   task automatic rx_char(input int bound, output logic got, output logic [7:0] ch,
                          output int gap, output logic ferr);
      got = 0; ch = '0; gap = 0; ferr = 0;
      @(negedge clk);
      while (con_txd !== 1'b0 && gap < bound) begin
         gap++;
         @(negedge clk);
      end
      if (con_txd === 1'b0) begin
         got = 1;
         repeat (8) @(negedge clk);
         if (con_txd !== 1'b0) ferr = 1;
         for (int k = 0; k < 8; k++) begin
            repeat (16) @(negedge clk);
            ch[k] = con_txd;
         end
         repeat (16) @(negedge clk);
         if (con_txd !== 1'b1) ferr = 1;
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int acks, at, stray;
      logic [35:0] rd;
      clken = 1; cpu_read = 0; cpu_write = 0; cpu_io = 0; cpu_addr = '0; cpu_data = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (txd_ack !== 1'b0 || txd_data !== 36'd0) begin
         n_fail++; $display("FAIL reset_bus: ack=%b data=%o, required 0/0", txd_ack, txd_data);
      end
      n_tests++;
      if (con_txd !== 1'b1 || tx_irq !== 1'b0) begin
         n_fail++; $display("FAIL reset_line: txd=%b irq=%b, required 1/0", con_txd, tx_irq);
      end
      rst_n = 1'b1;
      @(negedge clk);
      bus_req(1'b0, 1'b1, BASE + 22'd1, 36'd0, 1, acks, rd, at, stray);
      n_tests++;
      if (acks != 1 || at != 1 || stray != 0) begin
         n_fail++; $display("FAIL reset_ack: acks=%0d at=%0d stray=%0d, required 1/1/0",
                            acks, at, stray);
      end
      n_tests++;
      if (rd !== 36'o000000000003) begin
         n_fail++; $display("FAIL reset_status: got %o, required 3", rd);
      end
      n_tests++;
      if (con_txd !== 1'b1 || tx_irq !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle: txd=%b irq=%b, required 1/0", con_txd, tx_irq);
      end
   endtask

   task automatic test_single_char();
      int acks, at, stray, errs;
      logic [35:0] rd;
      logic [9:0] frame;
      frame = {1'b1, 8'h41, 1'b0};
      bus_req(1'b1, 1'b1, BASE, 36'o000000000101, 1, acks, rd, at, stray);
      n_tests++;
      if (con_txd !== 1'b1) begin
         n_fail++; $display("FAIL char_latency: txd=%b one cycle after ack, required 1", con_txd);
      end
      for (int b = 0; b < 10; b++) begin
         errs = 0;
         for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (con_txd !== frame[b]) errs++;
         end
         n_tests++;
         if (errs != 0) begin
            n_fail++; $display("FAIL char_bit%0d: %0d of 16 samples wrong, required level %b",
                               b, errs, frame[b]);
         end
      end
      @(negedge clk);
      n_tests++;
      if (con_txd !== 1'b1) begin
         n_fail++; $display("FAIL char_end: txd=%b after 160 clk, required 1", con_txd);
      end
      bus_req(1'b0, 1'b1, BASE + 22'd1, 36'd0, 1, acks, rd, at, stray);
      n_tests++;
      if (rd !== 36'o3) begin
         n_fail++; $display("FAIL char_status: got %o, required 3", rd);
      end
   endtask

   task automatic test_back_to_back();
      int acks_a, at_a, stray_a, gap;
      int acks_c, at_c, stray_c;
      logic [35:0] rd_a, rd_c;
      logic got, ferr;
      logic [7:0] ch;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               bus_req(1'b1, 1'b1, BASE, 36'(8'h30 + i), 1, acks_a, rd_a, at_a, stray_a);
            end
            // First char in the shifter, eight queued, the tenth dropped.
            bus_req(1'b0, 1'b1, BASE + 22'd1, 36'd0, 1, acks_a, rd_a, at_a, stray_a);
            n_tests++;
            if (rd_a !== 36'o4) begin
               n_fail++; $display("FAIL b2b_status_busy: got %o, required 4", rd_a);
            end
         end
         begin
            for (int i = 0; i < 9; i++) begin
               rx_char(100, got, ch, gap, ferr);
               n_tests++;
               if (!got || ferr || ch !== 8'(8'h30 + i) || (i > 0 && gap != 7)) begin
                  n_fail++;
                  $display("FAIL b2b_char%0d: got=%b ferr=%b ch=%h gap=%0d, required 1/0/%h/7",
                           i, got, ferr, ch, gap, 8'(8'h30 + i));
               end
            end
            rx_char(300, got, ch, gap, ferr);
            n_tests++;
            if (got) begin
               n_fail++; $display("FAIL b2b_tenth: extra char %h sent, required none", ch);
            end
         end
      join
      bus_req(1'b0, 1'b1, BASE + 22'd1, 36'd0, 1, acks_c, rd_c, at_c, stray_c);
      n_tests++;
      if (rd_c !== 36'o7) begin
         n_fail++; $display("FAIL b2b_status_idle: got %o, required 7", rd_c);
      end
      bus_req(1'b1, 1'b1, BASE + 22'd1, 36'o4, 1, acks_c, rd_c, at_c, stray_c);
      bus_req(1'b0, 1'b1, BASE + 22'd1, 36'd0, 1, acks_c, rd_c, at_c, stray_c);
      n_tests++;
      if (rd_c !== 36'o3) begin
         n_fail++; $display("FAIL b2b_ovf_clear: got %o, required 3", rd_c);
      end
   endtask

   task automatic test_irq();
      int acks, at, stray;
      logic [35:0] rd;
      bus_req(1'b1, 1'b1, BASE + 22'd1, 36'o010, 1, acks, rd, at, stray);
      @(negedge clk);
      n_tests++;
      if (tx_irq !== 1'b1) begin
         n_fail++; $display("FAIL irq_rise: irq=%b, required 1", tx_irq);
      end
      bus_req(1'b0, 1'b1, BASE + 22'd1, 36'd0, 1, acks, rd, at, stray);
      n_tests++;
      if (rd !== 36'o013) begin
         n_fail++; $display("FAIL irq_status: got %o, required 13", rd);
      end
      for (int i = 0; i < 9; i++) begin
         bus_req(1'b1, 1'b1, BASE, 36'h41, 1, acks, rd, at, stray);
      end
      @(negedge clk);
      n_tests++;
      if (tx_irq !== 1'b0) begin
         n_fail++; $display("FAIL irq_fall: irq=%b with FIFO full, required 0", tx_irq);
      end
      bus_req(1'b0, 1'b1, BASE + 22'd1, 36'd0, 1, acks, rd, at, stray);
      n_tests++;
      if (rd !== 36'o010) begin
         n_fail++; $display("FAIL irq_full_status: got %o, required 10", rd);
      end
   endtask

   task automatic test_decode();
      int acks, at, stray, lows;
      logic [35:0] rd;
      bus_req(1'b0, 1'b1, BASE + 22'd2, 36'd0, 2, acks, rd, at, stray);
      n_tests++;
      if (acks != 0 || stray != 0) begin
         n_fail++; $display("FAIL dec_addr_rd: acks=%0d stray=%0d, required 0/0", acks, stray);
      end
      bus_req(1'b1, 1'b1, BASE + 22'd2, 36'h41, 2, acks, rd, at, stray);
      n_tests++;
      if (acks != 0 || stray != 0) begin
         n_fail++; $display("FAIL dec_addr_wr: acks=%0d stray=%0d, required 0/0", acks, stray);
      end
      bus_req(1'b1, 1'b0, BASE, 36'h41, 2, acks, rd, at, stray);
      n_tests++;
      if (acks != 0 || stray != 0) begin
         n_fail++; $display("FAIL dec_mem_space: acks=%0d stray=%0d, required 0/0", acks, stray);
      end
      lows = 0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (con_txd !== 1'b1) lows++;
      end
      bus_req(1'b0, 1'b1, BASE + 22'd1, 36'd0, 1, acks, rd, at, stray);
      n_tests++;
      if (rd !== 36'o3 || lows != 0) begin
         n_fail++; $display("FAIL dec_fifo: status=%o low_samples=%0d, required 3/0", rd, lows);
      end
   endtask

   task automatic test_clken();
      int acks, at, stray, waited, lows;
      logic [35:0] rd;
      clken = 1'b0;
      @(negedge clk);
      cpu_read = 1; cpu_io = 1; cpu_addr = BASE + 22'd1;
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (txd_ack === 1'b1) acks++;
      end
      n_tests++;
      if (acks != 0) begin
         n_fail++; $display("FAIL clken_noack: acks=%0d while disabled, required 0", acks);
      end
      clken = 1'b1;
      @(negedge clk);
      n_tests++;
      if (txd_ack !== 1'b1 || txd_data !== 36'o3) begin
         n_fail++; $display("FAIL clken_ack: ack=%b data=%o, required 1/3", txd_ack, txd_data);
      end
      cpu_read = 0; cpu_io = 0; cpu_addr = '0;
      @(negedge clk);
      // A zero byte keeps the line low for start + 8 data bits; 20 frozen cycles stretch it.
      bus_req(1'b1, 1'b1, BASE, 36'h00, 1, acks, rd, at, stray);
      waited = 0;
      while (con_txd !== 1'b0 && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      lows = 0;
      while (con_txd === 1'b0 && lows < 400) begin
         lows++;
         if (lows == 50) clken = 1'b0;
         if (lows == 70) clken = 1'b1;
         @(negedge clk);
      end
      clken = 1'b1;
      n_tests++;
      if (lows != 164) begin
         n_fail++; $display("FAIL clken_freeze: low run %0d clk, required 164", lows);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_hold_and_abort();
      int acks, at, stray, gap, waited;
      logic [35:0] rd;
      logic got, ferr;
      logic [7:0] ch;
      bus_req(1'b1, 1'b1, BASE, 36'h55, 5, acks, rd, at, stray);
      n_tests++;
      if (acks != 1 || at != 1) begin
         n_fail++; $display("FAIL hold_ack: acks=%0d at=%0d, required 1/1", acks, at);
      end
      rx_char(50, got, ch, gap, ferr);
      n_tests++;
      if (!got || ferr || ch !== 8'h55) begin
         n_fail++; $display("FAIL hold_char: got=%b ferr=%b ch=%h, required 1/0/55", got, ferr, ch);
      end
      rx_char(200, got, ch, gap, ferr);
      n_tests++;
      if (got) begin
         n_fail++; $display("FAIL hold_single_push: second char %h sent, required none", ch);
      end
      bus_req(1'b1, 1'b1, BASE, 36'h55, 1, acks, rd, at, stray);
      waited = 0;
      while (con_txd !== 1'b0 && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      repeat (40) @(negedge clk);
      n_tests++;
      if (con_txd !== 1'b0) begin
         n_fail++; $display("FAIL abort_pre: txd=%b in data bit 1 of 55, required 0", con_txd);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (con_txd !== 1'b1 || txd_ack !== 1'b0 || tx_irq !== 1'b0) begin
         n_fail++; $display("FAIL abort_async: txd=%b ack=%b irq=%b, required 1/0/0",
                            con_txd, txd_ack, tx_irq);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus_req(1'b0, 1'b1, BASE + 22'd1, 36'd0, 1, acks, rd, at, stray);
      n_tests++;
      if (rd !== 36'o3) begin
         n_fail++; $display("FAIL abort_status: got %o, required 3", rd);
      end
      rx_char(200, got, ch, gap, ferr);
      n_tests++;
      if (got) begin
         n_fail++; $display("FAIL abort_lost: char %h sent after reset, required none", ch);
      end
   endtask

   initial begin
      test_reset();
      test_single_char();
      test_back_to_back();
      test_irq();
      apply_reset();
      test_decode();
      test_clken();
      test_hold_and_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
